// File: rtl/serial_mode_scheduler.sv
// Sequencer that walks an OUT_H x OUT_W grid of window positions, drives the
// serial engine through en/feature_baseaddr, and stores each result in a buffer.
module serial_mode_scheduler #(
   parameter int IMG_W   = 5,
   parameter int OUT_W   = 3,
   parameter int OUT_H   = 3,
   parameter int TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start_i,
   input  logic [7:0] img_baseaddr_i,
   output logic       en_o,
   output logic [7:0] feature_baseaddr_o,
   input  logic       is_done_i,
   input  logic [7:0] out_i,
   output logic       res_we_o,
   output logic [7:0] res_addr_o,
   output logic [7:0] res_data_o,
   output logic       busy_o,
   output logic       done_o,
   output logic       err_o,
   output logic [2:0] dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_RUN   = 3'd2,
      S_WRITE = 3'd3,
      S_DONE  = 3'd4,
      S_ERROR = 3'd5
   } state_t;

   localparam int WD_W = $clog2(TIMEOUT + 1);
   localparam logic [7:0]      IMG_W8   = 8'(IMG_W);
   localparam logic [7:0]      OUT_W8   = 8'(OUT_W);
   localparam logic [7:0]      LAST_ROW = 8'(OUT_H - 1);
   localparam logic [7:0]      LAST_COL = 8'(OUT_W - 1);
   localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT - 1);

   state_t          state, next_state;
   logic [7:0]      base, row, col;
   logic [WD_W-1:0] wd;
   logic [7:0]      feat_addr, res_addr, res_data;
   logic            err;

   logic            done_seen, wd_expired, last_pos;
   logic [7:0]      win_addr, res_idx;

   // Engine handshake: en high requests work on the window at feature_baseaddr;
   // is_done is accepted only while en is high and only from the second RUN
   // cycle, so a level left over from the previous position is never taken.
   assign done_seen  = is_done_i && (wd != '0);
   assign wd_expired = (wd == WD_LAST);
   assign last_pos   = (row == LAST_ROW) && (col == LAST_COL);
   assign win_addr   = base + row * IMG_W8 + col;
   assign res_idx    = row * OUT_W8 + col;

   assign feature_baseaddr_o = feat_addr;
   assign res_addr_o         = res_addr;
   assign res_data_o         = res_data;
   assign err_o              = err;
   assign dbg_state          = state;

   always_comb begin
      next_state = state;
      en_o       = 1'b0;
      res_we_o   = 1'b0;
      done_o     = 1'b0;
      busy_o     = 1'b1;
      case (state)
         S_IDLE, S_ERROR: begin
            busy_o = 1'b0;
            if (start_i) next_state = S_ISSUE;
         end
         S_ISSUE: next_state = S_RUN;
         S_RUN: begin
            en_o = 1'b1;
            if (done_seen)       next_state = S_WRITE;
            else if (wd_expired) next_state = S_ERROR;
         end
         S_WRITE: begin
            res_we_o   = 1'b1;
            next_state = last_pos ? S_DONE : S_ISSUE;
         end
         S_DONE: begin
            done_o     = 1'b1;
            next_state = S_IDLE;
         end
         default: begin
            busy_o     = 1'b0;
            next_state = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         base      <= '0;
         row       <= '0;
         col       <= '0;
         wd        <= '0;
         feat_addr <= '0;
         res_addr  <= '0;
         res_data  <= '0;
         err       <= 1'b0;
      end else begin
         state <= next_state;
         case (state)
            S_IDLE, S_ERROR: begin
               if (start_i) begin
                  base <= img_baseaddr_i;
                  row  <= '0;
                  col  <= '0;
                  err  <= 1'b0;
               end
            end
            S_ISSUE: begin
               feat_addr <= win_addr;
               wd        <= '0;
            end
            S_RUN: begin
               wd <= wd + WD_W'(1);
               if (done_seen) begin
                  res_data <= out_i;
                  res_addr <= res_idx;
               end else if (wd_expired) begin
                  err <= 1'b1;
               end
            end
            S_WRITE: begin
               if (!last_pos) begin
                  if (col == LAST_COL) begin
                     col <= '0;
                     row <= row + 8'd1;
                  end else begin
                     col <= col + 8'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_mode_scheduler.sv
// Scoreboard bench for serial_mode_scheduler: an engine model answers en with
// done after a delay; window addresses, writes and done pulses are checked.
module tb_serial_mode_scheduler;

   localparam int IMG_W   = 5;
   localparam int OUT_W   = 3;
   localparam int OUT_H   = 3;
   localparam int TIMEOUT = 10;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start_i = 1'b0;
   logic [7:0] img_baseaddr_i = '0;
   logic       en_o;
   logic [7:0] feature_baseaddr_o;
   logic       is_done_i = 1'b0;
   logic [7:0] out_i = '0;
   logic       res_we_o;
   logic [7:0] res_addr_o;
   logic [7:0] res_data_o;
   logic       busy_o;
   logic       done_o;
   logic       err_o;
   logic [2:0] dbg_state;

   serial_mode_scheduler #(
      .IMG_W(IMG_W), .OUT_W(OUT_W), .OUT_H(OUT_H), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst), .start_i(start_i), .img_baseaddr_i(img_baseaddr_i),
      .en_o(en_o), .feature_baseaddr_o(feature_baseaddr_o), .is_done_i(is_done_i),
      .out_i(out_i), .res_we_o(res_we_o), .res_addr_o(res_addr_o),
      .res_data_o(res_data_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
      .dbg_state(dbg_state)
   );

   // clock / reset
   initial forever #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // scoreboard queues
   logic [7:0] addr_q[$];
   logic [7:0] idx_q[$];
   logic [7:0] data_q[$];

   // engine model controls
   logic eng_fixed = 1'b1;
   logic eng_stale = 1'b0;
   logic eng_hang  = 1'b0;
   int   eng_cnt   = 0;
   int   eng_dly   = 5;

   initial begin
      logic [7:0] v;
      forever begin
         @(negedge clk);
         if (en_o) begin
            eng_cnt++;
            if (eng_cnt == 1) eng_dly = eng_fixed ? 5 : $urandom_range(2, 6);
         end else begin
            eng_cnt = 0;
         end
         is_done_i = 1'b0;
         out_i     = 8'($urandom_range(0, 255));
         if (!eng_hang) begin
            if (eng_stale && (!en_o || eng_cnt == 1)) begin
               is_done_i = 1'b1;
               out_i     = 8'hEE;
            end else if (en_o && eng_cnt == eng_dly) begin
               v = 8'($urandom_range(0, 255));
               is_done_i = 1'b1;
               out_i     = v;
               data_q.push_back(v);
            end
         end
      end
   end

   // monitor
   logic prev_en = 1'b0;
   logic prev_we = 1'b0;
   logic gap_armed = 1'b0;
   int   low_cnt = 0;
   int   en_rises = 0;
   int   wr_cnt = 0;
   int   done_cnt = 0;

   initial begin
      forever begin
         @(negedge clk);
         if (en_o && !prev_en) begin
            en_rises++;
            if (addr_q.size() == 0) check_eq("feat_unexpected", 1, 0);
            else check_eq("feat_addr", feature_baseaddr_o, addr_q.pop_front());
            if (gap_armed) check_eq("en_gap", low_cnt, 2);
            gap_armed = 1'b1;
         end
         if (res_we_o) begin
            wr_cnt++;
            if (idx_q.size() == 0) check_eq("wr_unexpected", 1, 0);
            else check_eq("res_addr", res_addr_o, idx_q.pop_front());
            if (data_q.size() == 0) check_eq("data_unexpected", 1, 0);
            else check_eq("res_data", res_data_o, data_q.pop_front());
         end
         if (done_o) begin
            done_cnt++;
            check_eq("done_after_wr", prev_we, 1);
         end
         if (en_o) low_cnt = 0;
         else low_cnt++;
         prev_en = en_o;
         prev_we = res_we_o;
      end
   end

   // driver tasks
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic flush_q();
      addr_q.delete();
      idx_q.delete();
      data_q.delete();
   endtask

   task automatic push_grid(input logic [7:0] base);
      for (int r = 0; r < OUT_H; r++)
         for (int c = 0; c < OUT_W; c++) begin
            addr_q.push_back(8'(int'(base) + r * IMG_W + c));
            idx_q.push_back(8'(r * OUT_W + c));
         end
   endtask

   task automatic run_grid(input logic [7:0] base, input logic poke);
      int d0, w0;
      gap_armed = 1'b0;
      push_grid(base);
      d0 = done_cnt;
      w0 = wr_cnt;
      start_i = 1'b1;
      img_baseaddr_i = base;
      tick();
      start_i = 1'b0;
      img_baseaddr_i = 8'h55;
      check_eq("issue_busy", busy_o, 1);
      check_eq("issue_en", en_o, 0);
      check_eq("issue_err_clr", err_o, 0);
      tick();
      check_eq("run_en", en_o, 1);
      for (int i = 0; i < 400 && done_cnt == d0; i++) begin
         if (poke && i == 10) begin
            start_i = 1'b1;
            img_baseaddr_i = 8'hAA;
         end
         if (poke && i == 11) start_i = 1'b0;
         tick();
      end
      start_i = 1'b0;
      check_eq("done_pulses", done_cnt - d0, 1);
      check_eq("write_count", wr_cnt - w0, OUT_W * OUT_H);
      check_eq("addr_q_left", addr_q.size(), 0);
      check_eq("data_q_left", data_q.size(), 0);
      tick();
      check_eq("idle_state", dbg_state, 0);
      check_eq("idle_busy", busy_o, 0);
      flush_q();
   endtask

   task automatic timeout_run(input logic [7:0] base);
      int rc, w0;
      eng_hang = 1'b1;
      gap_armed = 1'b0;
      addr_q.push_back(base);
      w0 = wr_cnt;
      start_i = 1'b1;
      img_baseaddr_i = base;
      tick();
      start_i = 1'b0;
      rc = 0;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (en_o) rc++;
         if (err_o) break;
      end
      check_eq("to_run_cycles", rc, TIMEOUT);
      check_eq("to_err", err_o, 1);
      check_eq("to_en", en_o, 0);
      check_eq("to_busy", busy_o, 0);
      check_eq("to_state", dbg_state, 5);
      repeat (3) tick();
      check_eq("to_err_sticky", err_o, 1);
      check_eq("to_no_writes", wr_cnt - w0, 0);
      eng_hang = 1'b0;
      flush_q();
   endtask

   task automatic reset_mid_run(input logic [7:0] base);
      int e0, w0;
      gap_armed = 1'b0;
      push_grid(base);
      e0 = en_rises;
      w0 = wr_cnt;
      start_i = 1'b1;
      img_baseaddr_i = base;
      tick();
      start_i = 1'b0;
      for (int i = 0; i < 200 && en_rises - e0 < 5; i++) tick();
      check_eq("rst_reach_pos5", en_rises - e0, 5);
      rst = 1'b1;
      tick();
      check_eq("rst_en", en_o, 0);
      check_eq("rst_we", res_we_o, 0);
      check_eq("rst_busy", busy_o, 0);
      check_eq("rst_feat", feature_baseaddr_o, 0);
      check_eq("rst_res_addr", res_addr_o, 0);
      check_eq("rst_res_data", res_data_o, 0);
      check_eq("rst_state", dbg_state, 0);
      rst = 1'b0;
      repeat (10) tick();
      check_eq("rst_writes", wr_cnt - w0, 4);
      flush_q();
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: got stuck expected finish");
      $fatal(1, "simulation time limit");
   end

   initial begin
      repeat (3) tick();
      check_eq("reset_state", dbg_state, 0);
      check_eq("reset_en", en_o, 0);
      check_eq("reset_we", res_we_o, 0);
      check_eq("reset_done", done_o, 0);
      check_eq("reset_err", err_o, 0);
      check_eq("reset_busy", busy_o, 0);
      check_eq("reset_feat", feature_baseaddr_o, 0);
      check_eq("reset_res_addr", res_addr_o, 0);
      check_eq("reset_res_data", res_data_o, 0);
      rst = 1'b0;
      tick();

      eng_fixed = 1'b1;
      run_grid(8'd0, 1'b0);
      eng_fixed = 1'b0;
      run_grid(8'd9, 1'b1);
      run_grid(8'd250, 1'b0);
      eng_stale = 1'b1;
      run_grid(8'd7, 1'b0);
      eng_stale = 1'b0;
      timeout_run(8'd3);
      run_grid(8'd3, 1'b0);
      reset_mid_run(8'd0);
      run_grid(8'd0, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
